// File: rtl/fifo_irq_pkg.sv
// Shared types and helpers for the FIFO interrupt controller slice.
package fifo_irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_ASSERT = 2'd2
    } irq_state_e;

    // irq_id needs at least one bit even for a single source
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_irq_controller_n_if.sv
// Status/config/interrupt bundle between the FIFO interrupt controller and its host.
interface fifo_irq_controller_n_if
    import fifo_irq_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int HOLDOFF_W = 8
);
    localparam int ID_W = id_width(NUM_SRC);

    logic [NUM_SRC-1:0]   src_raw;
    logic [NUM_SRC-1:0]   cfg_enable;
    logic [NUM_SRC-1:0]   cfg_edge;
    logic [HOLDOFF_W-1:0] cfg_holdoff;
    logic [NUM_SRC-1:0]   clr;
    logic [NUM_SRC-1:0]   set;
    logic [NUM_SRC-1:0]   pending;
    logic                 irq;
    logic [ID_W-1:0]      irq_id;
    logic                 irq_id_valid;

    modport master (
        output src_raw, cfg_enable, cfg_edge, cfg_holdoff, clr, set,
        input  pending, irq, irq_id, irq_id_valid
    );

    modport slave (
        input  src_raw, cfg_enable, cfg_edge, cfg_holdoff, clr, set,
        output pending, irq, irq_id, irq_id_valid
    );

endinterface

// File: rtl/fifo_irq_controller_n_sync.sv
// Per-bit multi-flop synchroniser for raw FIFO flags; SYNC_STAGES = 0 passes through.
module fifo_irq_sync #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign q_o = d_i;
        end else begin : g_sync
            logic [WIDTH-1:0] stage_q [SYNC_STAGES];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q_o = stage_q[SYNC_STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/fifo_irq_controller_n.sv
// FIFO status interrupt controller: sync, edge/level capture, pending latch, coalesced irq.
//   state     | meaning
//   ST_IDLE   | no enabled source pending
//   ST_HOLD   | enabled source pending, hold-off counting down
//   ST_ASSERT | irq driven high until no enabled source pending
module fifo_irq_controller_n
    import fifo_irq_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fifo_irq_controller_n_if.slave  bus
);

    localparam int ID_W   = id_width(NUM_SRC);
    localparam int WU_MAX = SYNC_STAGES + 1;
    localparam int WU_W   = $clog2(WU_MAX + 1);

    logic [NUM_SRC-1:0]   src_s;
    logic [NUM_SRC-1:0]   src_prev_q;
    logic [NUM_SRC-1:0]   edge_evt;
    logic [NUM_SRC-1:0]   event_v;
    logic [NUM_SRC-1:0]   pending_q, pending_d;
    logic [NUM_SRC-1:0]   active_vec;
    logic                 active;
    logic [ID_W-1:0]      irq_id_d;
    logic [WU_W-1:0]      wu_q;
    logic                 warm_done;
    logic [HOLDOFF_W-1:0] cnt_q, cnt_d;
    irq_state_e           state_q, state_d;

    fifo_irq_sync #(
        .WIDTH       (NUM_SRC),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.src_raw),
        .q_o   (src_s)
    );

    // Edges are ignored until the synchroniser has flushed its reset zeros
    assign warm_done = (wu_q == WU_W'(WU_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wu_q       <= '0;
            src_prev_q <= '0;
            pending_q  <= '0;
        end else begin
            if (!warm_done) begin
                wu_q <= wu_q + 1'b1;
            end
            src_prev_q <= src_s;
            pending_q  <= pending_d;
        end
    end

    assign edge_evt  = src_s & ~src_prev_q & {NUM_SRC{warm_done}};
    assign event_v   = (bus.cfg_edge & edge_evt) | (~bus.cfg_edge & src_s);
    assign pending_d = (pending_q | bus.set | event_v) & ~bus.clr;

    assign active_vec = pending_q & bus.cfg_enable;
    assign active     = |active_vec;

    always_comb begin
        irq_id_d = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active_vec[i]) begin
                irq_id_d = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (active) begin
                    state_d = ST_HOLD;
                    cnt_d   = bus.cfg_holdoff;
                end
            end
            ST_HOLD: begin
                if (!active) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_ASSERT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ASSERT: begin
                if (!active) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.pending      = pending_q;
    assign bus.irq          = (state_q == ST_ASSERT);
    assign bus.irq_id       = irq_id_d;
    assign bus.irq_id_valid = active;

endmodule

// File: tb/tb_fifo_irq_controller_n.sv
// Scoreboard bench for fifo_irq_controller_n with NUM_SRC=4, SYNC_STAGES=2, HOLDOFF_W=8.
module tb_fifo_irq_controller_n;
    import fifo_irq_pkg::*;

    localparam int NS = 4;
    localparam int SS = 2;
    localparam int HW = 8;

    // observation word: {pending[3:0], irq, irq_id[1:0], irq_id_valid}
    localparam logic [7:0] M_PEND = 8'hF0;
    localparam logic [7:0] M_IRQ  = 8'h08;
    localparam logic [7:0] M_ID   = 8'h06;
    localparam logic [7:0] M_VLD  = 8'h01;
    localparam logic [7:0] M_ALL  = 8'hFF;

    typedef struct {
        int         cyc;
        logic [7:0] mask;
        logic [7:0] val;
        string      tag;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    fifo_irq_controller_n_if #(.NUM_SRC(NS), .HOLDOFF_W(HW)) bus();

    fifo_irq_controller_n #(
        .NUM_SRC     (NS),
        .SYNC_STAGES (SS),
        .HOLDOFF_W   (HW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs();
        return {bus.pending, bus.irq, bus.irq_id, bus.irq_id_valid};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push(input int c, input logic [7:0] m, input logic [7:0] v, input string t);
        exp_t x;
        x.cyc = c; x.mask = m; x.val = v; x.tag = t;
        sb.push_back(x);
    endtask

    task automatic start(input logic [3:0] s, input logic [3:0] md, input logic [3:0] en,
                         input logic [7:0] ho);
        rst_n           = 1'b0;
        bus.src_raw     = s;
        bus.cfg_edge    = md;
        bus.cfg_enable  = en;
        bus.cfg_holdoff = ho;
        bus.clr         = '0;
        bus.set         = '0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        bus.src_raw     = 4'hF;
        bus.cfg_edge    = 4'h0;
        bus.cfg_enable  = 4'hF;
        bus.cfg_holdoff = 8'd0;
        bus.clr         = 4'h0;
        bus.set         = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs() !== 8'h00) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b", obs(), 8'h00);
        end
        bus.set = 4'h0;
    endtask

    task automatic test_level();
        exp_t e;
        start(4'b0010, 4'b0000, 4'b0010, 8'd0);
        push(2, M_PEND, 8'h00, "level_pend_early");
        push(3, M_PEND | M_ID | M_VLD, {4'b0010, 1'b0, 2'd1, 1'b1}, "level_pend_lat");
        push(4, M_IRQ, 8'h00, "level_irq_early");
        push(5, M_ALL, {4'b0010, 1'b1, 2'd1, 1'b1}, "level_irq_on");
        for (int k = 0; k < 6; k++) begin
            step();
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if ((obs() & e.mask) !== (e.val & e.mask)) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b mask=%b", e.tag, cyc, obs(), e.val, e.mask);
                end
            end
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL level_drain left=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_edge_warmup();
        exp_t e;
        start(4'b0001, 4'b0001, 4'b0001, 8'd0);
        push(3,  M_PEND, 8'h00, "edge_warm_3");
        push(4,  M_PEND, 8'h00, "edge_warm_4");
        push(10, M_PEND, 8'h00, "edge_warm_10");
        push(19, M_PEND, 8'h00, "edge_fall_19");
        push(22, M_PEND, 8'h00, "edge_pre_22");
        push(23, M_PEND | M_VLD, {4'b0001, 3'b000, 1'b1}, "edge_pend_23");
        push(25, M_IRQ | M_ID, {4'b0000, 1'b1, 2'd0, 1'b0}, "edge_irq_25");
        for (int k = 0; k < 26; k++) begin
            step();
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if ((obs() & e.mask) !== (e.val & e.mask)) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b mask=%b", e.tag, cyc, obs(), e.val, e.mask);
                end
            end
            if (cyc == 17) bus.src_raw = 4'b0000;
            if (cyc == 20) bus.src_raw = 4'b0001;
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL edge_drain left=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_set_clr();
        exp_t e;
        start(4'b0100, 4'b0000, 4'b0000, 8'd0);
        push(3, M_PEND, {4'b0100, 4'h0}, "setclr_level");
        push(6, M_PEND, {4'b1000, 4'h0}, "setclr_clr_wins");
        push(7, M_PEND | M_IRQ | M_VLD, {4'b1100, 4'h0}, "setclr_relevel");
        for (int k = 0; k < 8; k++) begin
            step();
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if ((obs() & e.mask) !== (e.val & e.mask)) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b mask=%b", e.tag, cyc, obs(), e.val, e.mask);
                end
            end
            if (cyc == 5) begin
                bus.clr = 4'b0100;
                bus.set = 4'b1100;
            end
            if (cyc == 6) begin
                bus.clr = 4'b0000;
                bus.set = 4'b0000;
            end
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL setclr_drain left=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_holdoff_abort();
        exp_t e;
        start(4'b0000, 4'b0000, 4'b1000, 8'd5);
        push(3,  M_PEND | M_ID | M_VLD, {4'b1000, 1'b0, 2'd3, 1'b1}, "abort_pend");
        push(6,  M_IRQ, 8'h00, "abort_hold3");
        push(7,  M_PEND | M_IRQ | M_VLD, 8'h00, "abort_cleared");
        push(9,  M_IRQ, 8'h00, "abort_no_irq_9");
        push(10, M_IRQ, 8'h00, "abort_no_irq_10");
        push(15, M_IRQ, 8'h00, "reload_irq_early");
        push(16, M_ALL, {4'b1000, 1'b1, 2'd3, 1'b1}, "reload_irq_on");
        for (int k = 0; k < 17; k++) begin
            step();
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if ((obs() & e.mask) !== (e.val & e.mask)) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b mask=%b", e.tag, cyc, obs(), e.val, e.mask);
                end
            end
            if (cyc == 2)  bus.set = 4'b1000;
            if (cyc == 3)  bus.set = 4'b0000;
            if (cyc == 6)  bus.clr = 4'b1000;
            if (cyc == 7)  bus.clr = 4'b0000;
            if (cyc == 10) begin
                bus.cfg_holdoff = 8'd3;
                bus.set         = 4'b1000;
            end
            if (cyc == 11) bus.set = 4'b0000;
            if (cyc == 13) bus.cfg_holdoff = 8'd0;
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL abort_drain left=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_id_mask();
        exp_t e;
        start(4'b0000, 4'b0000, 4'b1111, 8'd0);
        push(3, M_ALL, {4'b1010, 1'b0, 2'd1, 1'b1}, "id_pend");
        push(5, M_ALL, {4'b1010, 1'b1, 2'd1, 1'b1}, "id_low_first");
        push(6, M_ALL, {4'b1010, 1'b1, 2'd3, 1'b1}, "id_masked_to_3");
        push(7, M_ALL, {4'b1010, 1'b0, 2'd0, 1'b0}, "id_all_masked");
        push(8, M_ALL, {4'b1010, 1'b0, 2'd0, 1'b0}, "id_masked_stays");
        for (int k = 0; k < 8; k++) begin
            step();
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if ((obs() & e.mask) !== (e.val & e.mask)) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b mask=%b", e.tag, cyc, obs(), e.val, e.mask);
                end
            end
            if (cyc == 2) bus.set = 4'b1010;
            if (cyc == 3) bus.set = 4'b0000;
            if (cyc == 5) bus.cfg_enable = 4'b1000;
            if (cyc == 6) bus.cfg_enable = 4'b0000;
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL id_drain left=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_reset_during_assert();
        exp_t e;
        start(4'b0011, 4'b0001, 4'b0011, 8'd0);
        push(3, M_PEND, {4'b0010, 4'h0}, "rst_pre_pend");
        push(5, M_ALL, {4'b0010, 1'b1, 2'd1, 1'b1}, "rst_pre_assert");
        for (int k = 0; k < 6; k++) begin
            step();
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if ((obs() & e.mask) !== (e.val & e.mask)) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b mask=%b", e.tag, cyc, obs(), e.val, e.mask);
                end
            end
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 8'h00) begin
            errors++;
            $display("FAIL rst_async_drop got=%b exp=%b", obs(), 8'h00);
        end
        bus.src_raw = 4'b0001;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        sb.delete();
        push(1,  M_PEND, 8'h00, "rst_warm_1");
        push(3,  M_PEND, 8'h00, "rst_warm_3");
        push(4,  M_PEND, 8'h00, "rst_warm_4");
        push(10, M_PEND | M_IRQ, 8'h00, "rst_warm_10");
        for (int k = 0; k < 10; k++) begin
            step();
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if ((obs() & e.mask) !== (e.val & e.mask)) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b mask=%b", e.tag, cyc, obs(), e.val, e.mask);
                end
            end
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL rst_drain left=%0d exp=0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.src_raw     = '0;
        bus.cfg_edge    = '0;
        bus.cfg_enable  = '0;
        bus.cfg_holdoff = '0;
        bus.clr         = '0;
        bus.set         = '0;
        test_reset();
        test_level();
        test_edge_warmup();
        test_set_clr();
        test_holdoff_abort();
        test_id_mask();
        test_reset_during_assert();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_irq_controller_n.md
FIFO_IRQ_CONTROLLER_N -- requirements
Module: fifo_irq_controller_n

Interface
REQ-001 Parameter NUM_SRC, default 4, number of FIFO status sources (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, input synchroniser depth (0 = bypass, else 2..4).
REQ-003 Parameter HOLDOFF_W, default 8, width of the coalescing hold-off counter.
REQ-004 clk  in  1  clock.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 src_raw  in  NUM_SRC  raw FIFO flags (full/empty/almost-*), possibly from other clock domains.
REQ-007 cfg_enable  in  NUM_SRC  per-source interrupt enable; gates irq only, not pending.
REQ-008 cfg_edge  in  NUM_SRC  per-source mode: 1 = rising edge, 0 = level.
REQ-009 cfg_holdoff  in  HOLDOFF_W  coalescing delay in cycles.
REQ-010 clr  in  NUM_SRC  write-1-to-clear pulse per source.
REQ-011 set  in  NUM_SRC  software force-set pulse per source.
REQ-012 pending  out  NUM_SRC  latched interrupt status.
REQ-013 irq  out  1  aggregated interrupt request, registered.
REQ-014 irq_id  out  ID_W  lowest-index enabled pending source; ID_W = max(1, clog2(NUM_SRC)).
REQ-015 irq_id_valid  out  1  high when any enabled source is pending.

Function
REQ-016 src_s SHALL equal src_raw delayed SYNC_STAGES cycles; src_s = src_raw combinationally when SYNC_STAGES = 0.
REQ-017 src_prev SHALL register src_s every cycle; edge event = src_s & ~src_prev; level event = src_s.
REQ-018 A warm-up counter SHALL suppress edge events (not level events) for SYNC_STAGES+1 cycles after reset release, so flags high at reset never produce edge interrupts.
REQ-019 pending[i] next: clr[i] -> 0 (highest priority); else set[i] or event[i] -> 1; else hold.
REQ-020 Latency src_raw -> pending SHALL be SYNC_STAGES+1 cycles; set -> pending 1 cycle.
REQ-021 A level-mode source still high after clr SHALL re-set pending on the following cycle.
REQ-022 active = |(pending & cfg_enable); irq_id_valid = active; irq_id = lowest i with pending[i] & cfg_enable[i], 0 when !active.
REQ-023 Coalescing FSM states IDLE, HOLD, ASSERT; irq = (state == ASSERT).
REQ-024 IDLE: if active -> HOLD, cnt <= cfg_holdoff; else stay.
REQ-025 HOLD: if !active -> IDLE; else if cnt == 0 -> ASSERT; else cnt <= cnt-1.
REQ-026 ASSERT: if !active -> IDLE; else stay.
REQ-027 Latency from first cycle active is high to irq high SHALL be cfg_holdoff+2 cycles; irq deasserts 1 cycle after active falls.
REQ-028 cfg_holdoff changes SHALL take effect only at the next IDLE->HOLD transition.
REQ-029 Masking all pending sources (cfg_enable -> 0) SHALL return the FSM to IDLE without clearing pending.

Reset
REQ-030 Reset SHALL force pending = 0, synchroniser flops = 0, src_prev = 0, warm-up counter = 0, cnt = 0, state = IDLE, irq = 0, irq_id = 0, irq_id_valid = 0.
REQ-031 Reset asserted mid-HOLD or mid-ASSERT SHALL drop irq within the same cycle (asynchronous) and restart warm-up on release.

Structure
REQ-032 Package fifo_irq_pkg SHALL hold the FSM state enum and the ID_W width function.
REQ-033 Sub-module fifo_irq_sync (per-bit vector synchroniser, parameter SYNC_STAGES, async reset to 0) SHALL implement REQ-016.

Verification (NUM_SRC=4, SYNC_STAGES=2, HOLDOFF_W=8)
REQ-034 Level src_raw[1]=1 from cycle 0, enable=4'b0010, holdoff=0 -> pending[1]=1 at cycle 3, irq=1 at cycle 5, irq_id=1.
REQ-035 Edge mode on src 0, src_raw[0] high through reset -> pending[0] stays 0; a later 0->1 toggle at cycle 20 -> pending[0]=1 at cycle 23.
REQ-036 clr[2] and set[2] in the same cycle, pending[2]=1 -> pending[2]=0 next cycle; level source still high -> pending[2]=1 the cycle after.
REQ-037 holdoff=5, pending[3] set, clr[3] at 3rd HOLD cycle -> irq never asserts, FSM back to IDLE.
REQ-038 pending=4'b1010, enable=4'b1111 -> irq_id=1; enable=4'b1000 -> irq_id=3; enable=0 -> irq=0 next cycle, pending unchanged.
REQ-039 rst_n low during ASSERT -> irq=0 immediately, all pending=0, no spurious edge event after release.
